// File: rtl/address_map_pipe_if.sv
// address_map_pipe_if
// Bundles the SNES sampler side, the MCU configuration port and the decode
// results of address_map_pipe into one interface.
//   master : drives the SNES address/strobe and the config write/commit port,
//            observes busy and the decode results (bus sampler / MCU / bench)
//   slave  : the address mapper itself
// Signals:
//   SNES_ADDR, SNES_ROMSEL, addr_strobe      sampled SNES bus cycle
//   cfg_we, cfg_addr, cfg_data, cfg_commit   MCU shadow-register port
//   cfg_busy                                 shadow-to-active copy pending
//   out_valid, ROM_ADDR, IS_ROM, IS_SAVERAM,
//   IS_WRITABLE, ROM_HIT, win_hit            decode results
interface address_map_pipe_if #(
    parameter int NUM_WIN = 8,
    parameter int ADDR_W  = 24
);
    logic [ADDR_W-1:0]  SNES_ADDR;
    logic               SNES_ROMSEL;
    logic               addr_strobe;
    logic               cfg_we;
    logic [7:0]         cfg_addr;
    logic [7:0]         cfg_data;
    logic               cfg_commit;
    logic               cfg_busy;
    logic               out_valid;
    logic [ADDR_W-1:0]  ROM_ADDR;
    logic               IS_ROM;
    logic               IS_SAVERAM;
    logic               IS_WRITABLE;
    logic               ROM_HIT;
    logic [NUM_WIN-1:0] win_hit;

    modport master (
        output SNES_ADDR, SNES_ROMSEL, addr_strobe,
        output cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  cfg_busy, out_valid, ROM_ADDR, IS_ROM, IS_SAVERAM,
        input  IS_WRITABLE, ROM_HIT, win_hit
    );

    modport slave (
        input  SNES_ADDR, SNES_ROMSEL, addr_strobe,
        input  cfg_we, cfg_addr, cfg_data, cfg_commit,
        output cfg_busy, out_valid, ROM_ADDR, IS_ROM, IS_SAVERAM,
        output IS_WRITABLE, ROM_HIT, win_hit
    );
endinterface

// File: rtl/address_map_pipe.sv
// address_map_pipe
// Two-stage pipelined SNES address decoder. Stage 1 latches the sampled SNES
// address, stage 2 maps it to a ROM/SRAM address and classifies it (ROM,
// SaveRAM, peripheral window hits). The MCU writes configuration into shadow
// registers; a commit copies them to the active set only once the pipeline
// is empty, so a decode never sees a half-updated configuration.
// Ports:
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  address_map_pipe_if.slave (SNES input, config port, decode results)
// ADDR_W must be at least 24; the SNES map occupies the low 24 bits.
module address_map_pipe #(
    parameter int NUM_WIN = 8,
    parameter int ADDR_W  = 24
) (
    input  logic              CLK,
    input  logic              RST,
    address_map_pipe_if.slave bus
);
    localparam logic [ADDR_W-1:0] SRAM_BASE = ADDR_W'(24'hE00000);

    logic [2:0]        shMapper_q, shMapper_d, actMapper_q;
    logic [ADDR_W-1:0] shSram_q, shSram_d, actSram_q;
    logic [ADDR_W-1:0] shRom_q, shRom_d, actRom_q;
    logic [15:0]       shVal_q [NUM_WIN];
    logic [15:0]       shVal_d [NUM_WIN];
    logic [15:0]       shMsk_q [NUM_WIN];
    logic [15:0]       shMsk_d [NUM_WIN];
    logic [15:0]       actVal_q [NUM_WIN];
    logic [15:0]       actMsk_q [NUM_WIN];

    logic              pending_q;
    logic              applyCfg;

    logic              s1Valid_q;
    logic [ADDR_W-1:0] s1Addr_q;
    logic              s1Romsel_q;

    logic              outValid_q;
    logic [ADDR_W-1:0] romAddr_q, decAddr;
    logic              isRom_q, decIsRom;
    logic              isSave_q, decIsSave;
    logic [NUM_WIN-1:0] winHit_q, decWin;

    // Shadow next-state: this cycle's MCU write is folded in here so that a
    // copy happening in the same cycle already includes it.
    always_comb begin
        shMapper_d = shMapper_q;
        shSram_d   = shSram_q;
        shRom_d    = shRom_q;
        shVal_d    = shVal_q;
        shMsk_d    = shMsk_q;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                8'h00:   shMapper_d       = bus.cfg_data[2:0];
                8'h01:   shSram_d[7:0]    = bus.cfg_data;
                8'h02:   shSram_d[15:8]   = bus.cfg_data;
                8'h03:   shSram_d[23:16]  = bus.cfg_data;
                8'h04:   shRom_d[7:0]     = bus.cfg_data;
                8'h05:   shRom_d[15:8]    = bus.cfg_data;
                8'h06:   shRom_d[23:16]   = bus.cfg_data;
                default: begin
                    for (int i = 0; i < NUM_WIN; i++) begin
                        if (bus.cfg_addr[7:2] == 6'(4 + i)) begin
                            case (bus.cfg_addr[1:0])
                                2'd0:    shVal_d[i][7:0]  = bus.cfg_data;
                                2'd1:    shVal_d[i][15:8] = bus.cfg_data;
                                2'd2:    shMsk_d[i][7:0]  = bus.cfg_data;
                                default: shMsk_d[i][15:8] = bus.cfg_data;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // The copy waits until nothing is in flight and no new address is
    // entering, so every decode uses one consistent configuration.
    assign applyCfg = pending_q & ~bus.addr_strobe & ~s1Valid_q & ~outValid_q;

    // Shadow, active and pending registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shMapper_q  <= 3'b111;
            shSram_q    <= '0;
            shRom_q     <= '0;
            actMapper_q <= 3'b111;
            actSram_q   <= '0;
            actRom_q    <= '0;
            pending_q   <= 1'b0;
            for (int i = 0; i < NUM_WIN; i++) begin
                shVal_q[i]  <= '0;
                shMsk_q[i]  <= '0;
                actVal_q[i] <= '0;
                actMsk_q[i] <= '0;
            end
        end else begin
            shMapper_q <= shMapper_d;
            shSram_q   <= shSram_d;
            shRom_q    <= shRom_d;
            shVal_q    <= shVal_d;
            shMsk_q    <= shMsk_d;
            if (applyCfg) begin
                actMapper_q <= shMapper_d;
                actSram_q   <= shSram_d;
                actRom_q    <= shRom_d;
                actVal_q    <= shVal_d;
                actMsk_q    <= shMsk_d;
                pending_q   <= 1'b0;
            end else begin
                pending_q   <= pending_q | bus.cfg_commit;
            end
        end
    end

    // Stage 1: capture the sampled SNES bus cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1Valid_q  <= 1'b0;
            s1Addr_q   <= '0;
            s1Romsel_q <= 1'b0;
        end else begin
            s1Valid_q <= bus.addr_strobe;
            if (bus.addr_strobe) begin
                s1Addr_q   <= bus.SNES_ADDR;
                s1Romsel_q <= bus.SNES_ROMSEL;
            end
        end
    end

    // Decode of the stage-1 address against the active configuration.
    // A SaveRAM hit takes precedence for the mapped address.
    always_comb begin
        decIsRom  = s1Addr_q[22] | s1Addr_q[15];
        decIsSave = 1'b0;
        decAddr   = '0;
        case (actMapper_q)
            3'b000, 3'b010: begin
                decIsSave = actSram_q[0] & ~s1Addr_q[22] & s1Addr_q[21] &
                            s1Addr_q[14] & s1Addr_q[13] & ~s1Addr_q[15];
                if (decIsSave)
                    decAddr = SRAM_BASE +
                              (ADDR_W'({s1Addr_q[20:16], s1Addr_q[12:0]}) & actSram_q);
                else if (actMapper_q == 3'b000)
                    decAddr = ADDR_W'({1'b0, s1Addr_q[22:0]}) & actRom_q;
                else
                    decAddr = ADDR_W'({1'b0, ~s1Addr_q[23], s1Addr_q[21:0]}) & actRom_q;
            end
            3'b001: begin
                decIsSave = actSram_q[0] & s1Addr_q[22] & s1Addr_q[21] &
                            s1Addr_q[20] & ~s1Romsel_q &
                            (~s1Addr_q[15] | ~actRom_q[21]);
                if (decIsSave)
                    decAddr = SRAM_BASE +
                              (ADDR_W'({s1Addr_q[20:16], s1Addr_q[14:0]}) & actSram_q);
                else
                    decAddr = ADDR_W'({2'b00, s1Addr_q[22:16], s1Addr_q[14:0]}) & actRom_q;
            end
            default: begin
                decIsSave = 1'b0;
                decAddr   = '0;
            end
        endcase
        for (int i = 0; i < NUM_WIN; i++) begin
            decWin[i] = (actMsk_q[i] != 16'h0) & ~s1Addr_q[22] &
                        (((s1Addr_q[15:0] ^ actVal_q[i]) & actMsk_q[i]) == 16'h0);
        end
    end

    // Stage 2: result registers hold their value between valid pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            outValid_q <= 1'b0;
            romAddr_q  <= '0;
            isRom_q    <= 1'b0;
            isSave_q   <= 1'b0;
            winHit_q   <= '0;
        end else begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                romAddr_q <= decAddr;
                isRom_q   <= decIsRom;
                isSave_q  <= decIsSave;
                winHit_q  <= decWin;
            end
        end
    end

    assign bus.cfg_busy    = pending_q;
    assign bus.out_valid   = outValid_q;
    assign bus.ROM_ADDR    = romAddr_q;
    assign bus.IS_ROM      = isRom_q;
    assign bus.IS_SAVERAM  = isSave_q;
    assign bus.IS_WRITABLE = isSave_q;
    assign bus.ROM_HIT     = isRom_q | isSave_q;
    assign bus.win_hit     = winHit_q;
endmodule

// File: tb/tb_address_map_pipe.sv
// tb_address_map_pipe
// Self-checking bench for address_map_pipe: a table of decode vectors, each
// with its own mapper/mask configuration and hand-computed results, followed
// by hand-written sequences for windows, commit under traffic and reset.
module tb_address_map_pipe;
    localparam int NUM_WIN = 8;
    localparam int ADDR_W  = 24;

    logic CLK;
    logic RST;
    int   testsRun;
    int   testsFailed;

    address_map_pipe_if #(.NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W)) bus ();

    address_map_pipe #(.NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  mapper;
        logic [23:0] sramMask;
        logic [23:0] romMask;
        logic [23:0] addr;
        logic        romsel;
        logic        expRom;
        logic        expSave;
        logic [23:0] expAddr;
    } vec_t;

    vec_t vecs [10];

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one clock; samples and drives happen 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic writeCfg(input logic [7:0] idx, input logic [7:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = idx;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic waitIdle();
        int cycles;
        cycles = 0;
        while (bus.cfg_busy && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("commit completes", 32'(bus.cfg_busy), 32'd0);
    endtask

    task automatic configure(input logic [2:0] mapper, input logic [23:0] sram,
                             input logic [23:0] rom);
        writeCfg(8'h00, {5'd0, mapper});
        writeCfg(8'h01, sram[7:0]);
        writeCfg(8'h02, sram[15:8]);
        writeCfg(8'h03, sram[23:16]);
        writeCfg(8'h04, rom[7:0]);
        writeCfg(8'h05, rom[15:8]);
        writeCfg(8'h06, rom[23:16]);
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        waitIdle();
    endtask

    // One-cycle strobe; returns right after the capturing edge.
    task automatic applyStimulus(input logic [23:0] addr, input logic romsel);
        bus.SNES_ADDR   = addr;
        bus.SNES_ROMSEL = romsel;
        bus.addr_strobe = 1'b1;
        tick();
        bus.addr_strobe = 1'b0;
    endtask

    task automatic checkDecode(input string name, input logic expRom,
                               input logic expSave, input logic [23:0] expAddr);
        checkOutput({name, " valid"},    32'(bus.out_valid),   32'd1);
        checkOutput({name, " IS_ROM"},   32'(bus.IS_ROM),      32'(expRom));
        checkOutput({name, " SAVERAM"},  32'(bus.IS_SAVERAM),  32'(expSave));
        checkOutput({name, " WRITABLE"}, 32'(bus.IS_WRITABLE), 32'(expSave));
        checkOutput({name, " ROM_HIT"},  32'(bus.ROM_HIT),     32'(expRom | expSave));
        checkOutput({name, " ROM_ADDR"}, 32'(bus.ROM_ADDR),    32'(expAddr));
    endtask

    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        RST             = 1'b1;
        bus.SNES_ADDR   = '0;
        bus.SNES_ROMSEL = 1'b1;
        bus.addr_strobe = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
        bus.cfg_commit  = 1'b0;

        vecs[0] = '{3'b111, 24'h000000, 24'h000000, 24'h008000, 1'b1, 1'b1, 1'b0, 24'h000000};
        vecs[1] = '{3'b000, 24'h001FFF, 24'h3FFFFF, 24'h306123, 1'b1, 1'b0, 1'b1, 24'hE00123};
        vecs[2] = '{3'b000, 24'h001FFF, 24'h3FFFFF, 24'hC12345, 1'b1, 1'b1, 1'b0, 24'h012345};
        vecs[3] = '{3'b000, 24'h001FFE, 24'h3FFFFF, 24'h306123, 1'b1, 1'b0, 1'b0, 24'h306123};
        vecs[4] = '{3'b010, 24'h001FFF, 24'h7FFFFF, 24'h008000, 1'b1, 1'b1, 1'b0, 24'h408000};
        vecs[5] = '{3'b001, 24'h007FFF, 24'h1FFFFF, 24'h708010, 1'b0, 1'b1, 1'b1, 24'hE00010};
        vecs[6] = '{3'b001, 24'h007FFF, 24'h1FFFFF, 24'h018000, 1'b0, 1'b1, 1'b0, 24'h008000};
        vecs[7] = '{3'b001, 24'h007FFF, 24'h1FFFFF, 24'h708010, 1'b1, 1'b1, 1'b0, 24'h180010};
        vecs[8] = '{3'b001, 24'h007FFF, 24'h3FFFFF, 24'h700010, 1'b0, 1'b1, 1'b1, 24'hE00010};
        vecs[9] = '{3'b011, 24'h007FFF, 24'h3FFFFF, 24'h408000, 1'b0, 1'b1, 1'b0, 24'h000000};

        // Reset state.
        repeat (3) tick();
        RST = 1'b0;
        checkOutput("reset busy",     32'(bus.cfg_busy),  32'd0);
        checkOutput("reset valid",    32'(bus.out_valid), 32'd0);
        checkOutput("reset ROM_ADDR", 32'(bus.ROM_ADDR),  32'd0);
        checkOutput("reset flags",
                    32'({bus.IS_ROM, bus.IS_SAVERAM, bus.IS_WRITABLE, bus.ROM_HIT}), 32'd0);
        checkOutput("reset win_hit",  32'(bus.win_hit),   32'd0);

        // Latency: strobe in N, valid only in N+2.
        applyStimulus(24'h008000, 1'b1);
        checkOutput("latency N+1", 32'(bus.out_valid), 32'd0);
        tick();
        checkDecode("reset decode", 1'b1, 1'b0, 24'h000000);
        checkOutput("reset decode win", 32'(bus.win_hit), 32'd0);
        tick();
        checkOutput("valid pulse width", 32'(bus.out_valid), 32'd0);
        checkOutput("output hold", 32'(bus.IS_ROM), 32'd1);

        // Table-driven decode vectors.
        for (int i = 0; i < 10; i++) begin
            configure(vecs[i].mapper, vecs[i].sramMask, vecs[i].romMask);
            applyStimulus(vecs[i].addr, vecs[i].romsel);
            tick();
            checkDecode($sformatf("vec%0d", i), vecs[i].expRom, vecs[i].expSave,
                        vecs[i].expAddr);
            checkOutput($sformatf("vec%0d win", i), 32'(bus.win_hit), 32'd0);
        end

        // Window 0 with back-to-back strobes.
        writeCfg(8'h10, 8'h00);
        writeCfg(8'h11, 8'h78);
        writeCfg(8'h12, 8'h00);
        writeCfg(8'h13, 8'hF8);
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
        waitIdle();
        bus.SNES_ROMSEL = 1'b1;
        bus.addr_strobe = 1'b1;
        bus.SNES_ADDR   = 24'h007FF0;
        tick();
        bus.SNES_ADDR   = 24'h407FF0;
        tick();
        checkOutput("win b2b 0 valid", 32'(bus.out_valid), 32'd1);
        checkOutput("win b2b 0 hit",   32'(bus.win_hit),   32'h01);
        bus.SNES_ADDR   = 24'h007000;
        tick();
        bus.addr_strobe = 1'b0;
        checkOutput("win b2b 1 valid", 32'(bus.out_valid), 32'd1);
        checkOutput("win b2b 1 hit",   32'(bus.win_hit),   32'h00);
        tick();
        checkOutput("win b2b 2 valid", 32'(bus.out_valid), 32'd1);
        checkOutput("win b2b 2 hit",   32'(bus.win_hit),   32'h00);
        tick();
        checkOutput("win b2b end", 32'(bus.out_valid), 32'd0);

        // Commit under continuous traffic: LoROM active, HiROM in shadow.
        configure(3'b001, 24'h007FFF, 24'h1FFFFF);
        writeCfg(8'h00, 8'h00);
        bus.SNES_ADDR   = 24'h708010;
        bus.SNES_ROMSEL = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.addr_strobe = 1'b1;
            bus.cfg_commit  = (k == 0);
            tick();
            checkOutput($sformatf("traffic busy %0d", k), 32'(bus.cfg_busy), 32'd1);
            if (k >= 1)
                checkDecode($sformatf("traffic old %0d", k - 1), 1'b1, 1'b1, 24'hE00010);
        end
        bus.addr_strobe = 1'b0;
        bus.cfg_commit  = 1'b0;
        tick();
        checkOutput("traffic busy N+5", 32'(bus.cfg_busy), 32'd1);
        checkDecode("traffic old 4", 1'b1, 1'b1, 24'hE00010);
        tick();
        checkOutput("traffic busy N+6", 32'(bus.cfg_busy), 32'd1);
        checkOutput("traffic drained", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("traffic busy N+7", 32'(bus.cfg_busy), 32'd0);
        applyStimulus(24'h708010, 1'b0);
        tick();
        checkDecode("traffic new", 1'b1, 1'b0, 24'h108010);

        // Same-cycle write+commit, then reset while pending.
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 8'h00;
        bus.cfg_data   = 8'h01;
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_we     = 1'b0;
        bus.cfg_commit = 1'b0;
        checkOutput("pending before reset", 32'(bus.cfg_busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("reset discards commit", 32'(bus.cfg_busy), 32'd0);
        tick();
        checkOutput("no late commit", 32'(bus.cfg_busy), 32'd0);
        applyStimulus(24'h708000, 1'b0);
        tick();
        checkDecode("after reset", 1'b1, 1'b0, 24'h000000);

        // Reset mid-pipeline drops the in-flight decode.
        applyStimulus(24'h008000, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("flush valid 0", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("flush valid 1", 32'(bus.out_valid), 32'd0);
        checkOutput("flush ROM_ADDR", 32'(bus.IS_ROM), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/address_map_pipe.md
Name: address_map_pipe

Overview:
- Parametrised, pipelined successor to the combinational SNES address decoder.
- Maps each latched SNES address to a ROM/SRAM address and classifies it: ROM, SaveRAM, writable, and NUM_WIN MCU-programmable peripheral windows.
- Configuration is written by the MCU into shadow registers. It is applied atomically on commit, and only when the decode pipeline is empty.
- Sits between the SNES bus sampler and the memory arbiter / peripheral enables.

Parameters:
NUM_WIN, 8, number of programmable peripheral windows (1..16)
ADDR_W, 24, SNES and ROM address width

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
SNES_ADDR  in  ADDR_W  SNES CPU address
SNES_ROMSEL  in  1  SNES /ROMSEL (low = ROM area)
addr_strobe  in  1  one-cycle pulse: sample SNES_ADDR/SNES_ROMSEL this cycle
cfg_we  in  1  MCU config write strobe
cfg_addr  in  8  config register index
cfg_data  in  8  config write data
cfg_commit  in  1  request shadow-to-active copy
cfg_busy  out  1  commit pending
out_valid  out  1  one-cycle pulse: decode outputs updated
ROM_ADDR  out  ADDR_W  mapped memory address
IS_ROM  out  1  address mapped as ROM
IS_SAVERAM  out  1  address mapped as SaveRAM
IS_WRITABLE  out  1  equals IS_SAVERAM
ROM_HIT  out  1  IS_ROM | IS_WRITABLE
win_hit  out  NUM_WIN  per-window hit flags

Behaviour:
- Config map, write-only via cfg_we; the written byte lands in the shadow register:
  - 0x00: mapper[2:0].
  - 0x01..0x03: SAVERAM_MASK, LSB first.
  - 0x04..0x06: ROM_MASK, LSB first.
  - 0x10+4i..0x13+4i for window i < NUM_WIN: VAL[7:0], VAL[15:8], MSK[7:0], MSK[15:8].
  - Writes to any other index are ignored.
- Commit:
  - cfg_commit sets pending; cfg_busy = pending.
  - The active registers are loaded from shadow in the first cycle with: pending=1, addr_strobe=0, stage1 valid=0 and stage2 valid=0. Pending clears in that same cycle.
  - A commit while pending is absorbed (no second copy).
  - Shadow writes made while pending are included in the eventual copy.
  - Decode always uses the active registers only; shadow writes never alter an in-flight decode.
- Pipeline:
  - Stage1: on addr_strobe, register SNES_ADDR and SNES_ROMSEL, and set s1_valid.
  - Stage2: decode the stage1 contents into output registers. out_valid=1 for exactly one cycle.
  - Latency: strobe in cycle N produces out_valid in N+2. Throughput is one per cycle, so back-to-back strobes are legal.
  - Outputs hold their values between out_valid pulses.
- Decode, with A = latched address:
  - IS_ROM = A[22] | A[15].
  - HiROM (000) and ExHiROM (010):
    - IS_SAVERAM = SRAM_MASK[0] & ~A[22] & A[21] & A[14] & A[13] & ~A[15].
    - SaveRAM address = 0xE00000 + ({A[20:16],A[12:0]} & SRAM_MASK).
    - HiROM ROM address = {1'b0,A[22:0]} & ROM_MASK.
    - ExHiROM ROM address = {1'b0,~A[23],A[21:0]} & ROM_MASK.
  - LoROM (001):
    - IS_SAVERAM = SRAM_MASK[0] & A[22] & A[21] & A[20] & ~ROMSEL & (~A[15] | ~ROM_MASK[21]).
    - SaveRAM address = 0xE00000 + ({A[20:16],A[14:0]} & SRAM_MASK).
    - ROM address = {2'b00,A[22:16],A[14:0]} & ROM_MASK.
  - Any other mapper: IS_ROM is still computed; IS_SAVERAM=0; ROM_ADDR=0.
  - All adds are truncated to ADDR_W.
- Windows: win_hit[i] = (MSK_i != 0) & ~A[22] & (((A[15:0] ^ VAL_i) & MSK_i) == 0). Windows are independent; multiple hits are allowed.
- Reset:
  - All outputs 0. s1_valid=0, pending=0.
  - Active and shadow registers: mapper=3'b111, masks=0, all VAL/MSK=0 (windows disabled).
  - RST during a pending commit discards it. RST mid-pipeline drops in-flight decodes, so no out_valid follows.
- Simultaneous events:
  - cfg_we and cfg_commit in the same cycle: the write is captured before pending is evaluated and is included in the copy.
  - addr_strobe and a pending apply in the same cycle: the strobe wins and the apply waits.

Test Plan:
- Reset, then a single strobe with A=0x008000 -> out_valid at N+2, IS_ROM=1, IS_SAVERAM=0, ROM_ADDR=0, win_hit=0.
- Config HiROM, SRAM_MASK=0x001FFF, ROM_MASK=0x3FFFFF, commit. Strobe A=0x306123 -> IS_SAVERAM=1, ROM_HIT=1, ROM_ADDR=0xE00123. Strobe A=0xC12345 -> IS_ROM=1, ROM_ADDR=0x012345.
- LoROM, ROM_MASK=0x1FFFFF, SRAM_MASK=0x007FFF. A=0x708010 with ROMSEL=0 -> IS_SAVERAM=1, ROM_ADDR=0xE00010. A=0x018000 -> ROM_ADDR=0x008000.
- Window 0 VAL=0x7800, MSK=0xF800, then three back-to-back strobes 0x007FF0, 0x407FF0, 0x007000 -> three consecutive out_valid pulses with win_hit[0]=1, 0, 0.
- Commit while strobes arrive every cycle for 5 cycles -> cfg_busy stays 1 and all 5 decodes use the old config. Active registers update on the 3rd cycle after the last strobe (strobes N..N+4, copy at N+7), and cfg_busy clears in that cycle.
- Write mapper=001 and commit in the same cycle as cfg_we; pulse RST while pending -> cfg_busy=0 and mapper stays 111. A subsequent strobe at 0x708000 -> IS_SAVERAM=0.
